// File: rtl/hdb3_decoder.sv
// HDB3 receive decoder: recovers NRZ data from the dual-rail ternary line,
// strips B/V substitution pulses and monitors line-code legality.
module hdb3_decoder #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_p,
  input  logic                 i_n,
  output logic                 o_data,
  output logic                 o_sync,
  output logic                 o_err,
  output logic [3:0]           o_err_flags,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam logic                 POL_POS = 1'b1;
  localparam logic                 POL_NEG = 1'b0;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  logic                 last_pol_q, last_pol_d;
  logic [3:0]           sh_q, sh_d;
  logic [1:0]           mk_q, mk_d;
  logic [2:0]           zrun_q, zrun_d;
  logic                 vpol_q, vpol_d;
  logic                 vseen_q, vseen_d;
  logic                 sync_q, sync_d;
  logic                 err_q, err_d;
  logic [3:0]           flags_q, flags_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic is_mark_s;
  logic is_ill_s;
  logic mark_pol_s;
  logic is_v_s;

  // Symbol classification, V detection and next-state computation.
  always_comb begin
    is_mark_s  = 1'b0;
    is_ill_s   = 1'b0;
    mark_pol_s = last_pol_q;
    case ({i_p, i_n})
      2'b10: begin
        is_mark_s  = 1'b1;
        mark_pol_s = POL_POS;
      end
      2'b01: begin
        is_mark_s  = 1'b1;
        mark_pol_s = POL_NEG;
      end
      2'b11:   is_ill_s = 1'b1;
      default: is_ill_s = 1'b0;
    endcase

    is_v_s = is_mark_s && (mark_pol_s == last_pol_q);

    // A V clears itself plus t-1..t-3; the t-3 slot is where a B pulse sits.
    if (is_v_s) begin
      sh_d = 4'b0000;
    end else begin
      sh_d = {sh_q[2:0], is_mark_s};
    end

    // Only t-1/t-2 matter for spacing; a mark at t-3 is always a legal B.
    mk_d = {mk_q[0], is_mark_s};

    if (is_mark_s) begin
      last_pol_d = mark_pol_s;
      zrun_d     = 3'd0;
      sync_d     = 1'b1;
    end else begin
      last_pol_d = last_pol_q;
      sync_d     = sync_q;
      if (zrun_q != 3'd4) begin
        zrun_d = zrun_q + 3'd1;
      end else begin
        zrun_d = zrun_q;
      end
    end

    if (is_v_s) begin
      vpol_d  = mark_pol_s;
      vseen_d = 1'b1;
    end else begin
      vpol_d  = vpol_q;
      vseen_d = vseen_q;
    end

    flags_d[0] = is_ill_s;
    flags_d[1] = sync_q && is_v_s && (mk_q != 2'b00);
    flags_d[2] = sync_q && is_v_s && vseen_q && (mark_pol_s == vpol_q);
    flags_d[3] = sync_q && !is_mark_s && (zrun_q == 3'd3);
    err_d      = |flags_d;

    if (err_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + ERR_CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_pol_q <= POL_NEG;
      sh_q       <= 4'b0000;
      mk_q       <= 2'b00;
      zrun_q     <= 3'd0;
      vpol_q     <= POL_NEG;
      vseen_q    <= 1'b0;
      sync_q     <= 1'b0;
      err_q      <= 1'b0;
      flags_q    <= 4'b0000;
      cnt_q      <= '0;
    end else begin
      last_pol_q <= last_pol_d;
      sh_q       <= sh_d;
      mk_q       <= mk_d;
      zrun_q     <= zrun_d;
      vpol_q     <= vpol_d;
      vseen_q    <= vseen_d;
      sync_q     <= sync_d;
      err_q      <= err_d;
      flags_q    <= flags_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_data      = sh_q[3];
  assign o_sync      = sync_q;
  assign o_err       = err_q;
  assign o_err_flags = flags_q;
  assign o_err_cnt   = cnt_q;

endmodule

// File: tb/tb_hdb3_decoder.sv
// Scoreboard bench for hdb3_decoder: directed substitution/error cases and
// a loopback against a behavioural HDB3 encoder.
module tb_hdb3_decoder;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          p, n;
  logic          o_data, o_sync, o_err;
  logic [3:0]    o_err_flags;
  logic [CW-1:0] o_err_cnt;

  always #5 clk = ~clk;

  hdb3_decoder #(.ERR_CNT_W(CW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_p         (p),
    .i_n         (n),
    .o_data      (o_data),
    .o_sync      (o_sync),
    .o_err       (o_err),
    .o_err_flags (o_err_flags),
    .o_err_cnt   (o_err_cnt)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  string      seg = "init";
  bit         exp_data_q[$];
  logic [3:0] exp_flags_q[$];
  logic       exp_sync;
  logic [CW-1:0] exp_cnt;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", seg, tag, act, exp, $time);
    end
  endtask

  // Drive one symbol; data expectation surfaces 3 cycles later, flags at once.
  task automatic drive_sym(input logic sp, input logic sn, input bit bit_exp, input logic [3:0] fl_exp);
    bit         d;
    logic [3:0] f;
    p = sp;
    n = sn;
    exp_data_q.push_back(bit_exp);
    exp_flags_q.push_back(fl_exp);
    if (sp ^ sn) exp_sync = 1'b1;
    if ((fl_exp != 4'b0000) && (exp_cnt != {CW{1'b1}})) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
    d = exp_data_q.pop_front();
    f = exp_flags_q.pop_front();
    check_val("data",  32'(o_data),      32'(d));
    check_val("flags", 32'(o_err_flags), 32'(f));
    check_val("err",   32'(o_err),       32'(|f));
    check_val("cnt",   32'(o_err_cnt),   32'(exp_cnt));
    check_val("sync",  32'(o_sync),      32'(exp_sync));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    p   = 1'b0;
    n   = 1'b0;
    #2;
    check_val("rst_data",  32'(o_data),      32'd0);
    check_val("rst_sync",  32'(o_sync),      32'd0);
    check_val("rst_err",   32'(o_err),       32'd0);
    check_val("rst_flags", 32'(o_err_flags), 32'd0);
    check_val("rst_cnt",   32'(o_err_cnt),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_data_q.delete();
    exp_flags_q.delete();
    repeat (3) exp_data_q.push_back(1'b0);
    exp_sync = 1'b0;
    exp_cnt  = '0;
  endtask

  task automatic flush3();
    repeat (3) drive_sym(1'b0, 1'b0, 1'b0, 4'b0000);
  endtask

  bit   data[200];
  logic lp[200];
  logic ln[200];

  initial begin
    bit last_pol;
    bit odd;
    int i;

    rst = 1'b1;
    p   = 1'b0;
    n   = 1'b0;
    do_reset();

    seg = "000V";
    drive_sym(1, 0, 1, 4'h0);
    drive_sym(0, 0, 0, 4'h0);
    drive_sym(0, 0, 0, 4'h0);
    drive_sym(0, 0, 0, 4'h0);
    drive_sym(1, 0, 0, 4'h0);
    flush3();

    seg = "B00V";
    do_reset();
    drive_sym(1, 0, 1, 4'h0);
    drive_sym(0, 1, 1, 4'h0);
    drive_sym(1, 0, 0, 4'h0);
    drive_sym(0, 0, 0, 4'h0);
    drive_sym(0, 0, 0, 4'h0);
    drive_sym(1, 0, 0, 4'h0);
    flush3();

    seg = "errors";
    do_reset();
    drive_sym(1, 0, 1, 4'h0);
    drive_sym(1, 1, 0, 4'h1);
    drive_sym(0, 1, 0, 4'h0);
    drive_sym(0, 0, 0, 4'h0);
    drive_sym(0, 1, 0, 4'h2);
    drive_sym(0, 0, 0, 4'h0);
    drive_sym(0, 0, 0, 4'h0);
    drive_sym(0, 0, 0, 4'h0);
    drive_sym(0, 1, 0, 4'h4);
    drive_sym(0, 0, 0, 4'h0);
    drive_sym(0, 0, 0, 4'h0);
    drive_sym(0, 0, 0, 4'h0);
    drive_sym(0, 0, 0, 4'h8);
    drive_sym(0, 0, 0, 4'h0);
    flush3();
    check_val("err_total", 32'(o_err_cnt), 32'd4);

    seg = "saturate";
    do_reset();
    repeat (20) drive_sym(1, 1, 0, 4'h1);
    check_val("cnt_sat", 32'(o_err_cnt), 32'd15);

    seg = "rst_mid";
    do_reset();
    drive_sym(1, 0, 1, 4'h0);
    drive_sym(0, 1, 1, 4'h0);
    drive_sym(1, 0, 0, 4'h0);
    drive_sym(0, 0, 0, 4'h0);
    do_reset();
    drive_sym(1, 0, 1, 4'h0);
    flush3();

    seg = "loopback";
    for (int k = 0; k < 200; k++) data[k] = 1'($urandom_range(0, 1));
    for (int k = 0; k < 4; k++)    data[k] = 1'b0;
    for (int k = 30; k < 34; k++)  data[k] = 1'b0;
    for (int k = 80; k < 88; k++)  data[k] = 1'b0;
    for (int k = 140; k < 145; k++) data[k] = 1'b0;
    data[199] = 1'b1;
    last_pol = 1'b0;
    odd      = 1'b0;
    i        = 0;
    while (i < 200) begin
      if ((i + 3 < 200) && !data[i] && !data[i+1] && !data[i+2] && !data[i+3]) begin
        for (int k = i; k < i + 4; k++) begin
          lp[k] = 1'b0;
          ln[k] = 1'b0;
        end
        if (!odd) begin
          last_pol = ~last_pol;
          lp[i] = last_pol;
          ln[i] = ~last_pol;
        end
        lp[i+3] = last_pol;
        ln[i+3] = ~last_pol;
        odd = 1'b0;
        i   = i + 4;
      end else if (data[i]) begin
        last_pol = ~last_pol;
        lp[i] = last_pol;
        ln[i] = ~last_pol;
        odd   = ~odd;
        i     = i + 1;
      end else begin
        lp[i] = 1'b0;
        ln[i] = 1'b0;
        i     = i + 1;
      end
    end
    do_reset();
    for (int k = 0; k < 200; k++) drive_sym(lp[k], ln[k], data[k], 4'h0);
    flush3();
    check_val("loop_cnt", 32'(o_err_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
